// File: rtl/led_pkg.sv
// Constants and state encoding shared by the SPI frame loader and the matrix driver.
// RAM geometry here must match the driver's frame RAMs.
package led_pkg;
  localparam logic [7:0] CMD_WRITE     = 8'h01;
  localparam int         WORDS_PER_RAM = 256;
  localparam int         ADDR_W        = 8;
  localparam int         DATA_W        = 16;
  localparam int         FRAME_WORDS   = 2 * WORDS_PER_RAM;
  localparam int         WCNT_W        = 9;
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(FRAME_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    DISCARD = 3'd4
  } state_t;
endpackage

// File: rtl/spi_byte_rx.sv
// Mode-0 SPI slave byte receiver, oversampled in the system clock domain.
// Byte valid one cycle after the detected SCK edge of its 8th bit; no backpressure.
module spi_byte_rx (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_spi_sck,
  input  logic       i_spi_cs_n,
  input  logic       i_spi_mosi,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_cs_fall,
  output logic       o_cs_rise
);
  logic       sck_s1, sck_s2, sck_s3;
  logic       cs_s1, cs_s2, cs_s3;
  logic       mosi_s1, mosi_s2;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [1:0] settle;
  logic       armed;
  logic       sck_rise;

  assign sck_rise  = sck_s2 & ~sck_s3;
  // A falling edge only counts once CS has been seen high after reset, so a
  // window that was already open when reset released never starts a command.
  assign o_cs_fall = armed & cs_s3 & ~cs_s2;
  assign o_cs_rise = cs_s2 & ~cs_s3;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_s3  <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_s3   <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      settle  <= 2'd0;
      armed   <= 1'b0;
    end else begin
      sck_s1  <= i_spi_sck;
      sck_s2  <= sck_s1;
      sck_s3  <= sck_s2;
      cs_s1   <= i_spi_cs_n;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      mosi_s1 <= i_spi_mosi;
      mosi_s2 <= mosi_s1;
      if (settle != 2'd3) settle <= settle + 2'd1;
      if (settle == 2'd3 && cs_s3) armed <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bit_cnt      <= 3'd0;
      shift        <= 8'h00;
      o_byte       <= 8'h00;
      o_byte_valid <= 1'b0;
    end else begin
      o_byte_valid <= 1'b0;
      if (cs_s2) begin
        bit_cnt <= 3'd0;
      end else if (sck_rise) begin
        shift   <= {shift[6:0], mosi_s2};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          o_byte       <= {shift[6:0], mosi_s2};
          o_byte_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/spi_frame_loader.sv
// Loads 512-word LED frames from an SPI slave link into the two frame RAMs; write strobe one cycle after each word's low byte.
// No backpressure. SPI_FRAME_LOADER_DBUF_EN adds o_bank and writes the inactive bank.
module spi_frame_loader
  import led_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_spi_sck,
  input  logic              i_spi_cs_n,
  input  logic              i_spi_mosi,
`ifdef SPI_FRAME_LOADER_DBUF_EN
  output logic [ADDR_W:0]   o_waddr,
  output logic              o_bank,
`else
  output logic [ADDR_W-1:0] o_waddr,
`endif
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_we_1,
  output logic              o_we_2,
  output logic              o_frame_done,
  output logic              o_busy
);
  logic [7:0]        rx_byte;
  logic              byte_valid;
  logic              cs_fall;
  logic              cs_rise;
  state_t            state;
  logic [WCNT_W-1:0] word_cnt;
  logic [7:0]        hi_byte;

  spi_byte_rx u_rx (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_spi_sck    (i_spi_sck),
    .i_spi_cs_n   (i_spi_cs_n),
    .i_spi_mosi   (i_spi_mosi),
    .o_byte       (rx_byte),
    .o_byte_valid (byte_valid),
    .o_cs_fall    (cs_fall),
    .o_cs_rise    (cs_rise)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      word_cnt     <= '0;
      hi_byte      <= 8'h00;
      o_waddr      <= '0;
      o_wdata      <= '0;
      o_we_1       <= 1'b0;
      o_we_2       <= 1'b0;
      o_frame_done <= 1'b0;
      o_busy       <= 1'b0;
`ifdef SPI_FRAME_LOADER_DBUF_EN
      o_bank       <= 1'b0;
`endif
    end else begin
      o_we_1       <= 1'b0;
      o_we_2       <= 1'b0;
      o_frame_done <= 1'b0;
      if (cs_rise) begin
        state  <= IDLE;
        o_busy <= 1'b0;
      end else begin
        case (state)
          IDLE: if (cs_fall) state <= CMD;
          CMD: if (byte_valid) begin
            if (rx_byte == CMD_WRITE) begin
              state    <= DATA_HI;
              o_busy   <= 1'b1;
              word_cnt <= '0;
            end else begin
              state <= DISCARD;
            end
          end
          DATA_HI: if (byte_valid) begin
            hi_byte <= rx_byte;
            state   <= DATA_LO;
          end
          DATA_LO: if (byte_valid) begin
            o_wdata  <= {hi_byte, rx_byte};
`ifdef SPI_FRAME_LOADER_DBUF_EN
            o_waddr  <= {~o_bank, word_cnt[ADDR_W-1:0]};
`else
            o_waddr  <= word_cnt[ADDR_W-1:0];
`endif
            o_we_1   <= ~word_cnt[WCNT_W-1];
            o_we_2   <= word_cnt[WCNT_W-1];
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == LAST_WORD) begin
              o_frame_done <= 1'b1;
              o_busy       <= 1'b0;
              state        <= DISCARD;
`ifdef SPI_FRAME_LOADER_DBUF_EN
              o_bank       <= ~o_bank;
`endif
            end else begin
              state <= DATA_HI;
            end
          end
          DISCARD: state <= DISCARD;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_frame_loader.sv
// Directed bench for spi_frame_loader: SPI driven at i_clk/4, strobes logged on the falling clock edge.
module tb_spi_frame_loader;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic sck = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
`ifdef SPI_FRAME_LOADER_DBUF_EN
  logic [8:0] waddr;
  logic       bank;
  localparam bit DBUF = 1'b1;
`else
  logic [7:0] waddr;
  localparam bit DBUF = 1'b0;
`endif
  logic [15:0] wdata;
  logic we_1, we_2, frame_done, busy;

  spi_frame_loader dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_spi_sck    (sck),
    .i_spi_cs_n   (cs_n),
    .i_spi_mosi   (mosi),
    .o_waddr      (waddr),
`ifdef SPI_FRAME_LOADER_DBUF_EN
    .o_bank       (bank),
`endif
    .o_wdata      (wdata),
    .o_we_1       (we_1),
    .o_we_2       (we_2),
    .o_frame_done (frame_done),
    .o_busy       (busy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail = 0;
  logic exp_bank = 1'b0;
  logic [15:0] exp_w [512];

  logic [8:0]  q_addr [$];
  logic [15:0] q_data [$];
  logic [1:0]  q_ram  [$];
  int done_cnt = 0;
  int done_idx = -1;
  int done_bad = 0;
  int busy_cycles = 0;

  always @(negedge i_clk) begin
    if (we_1 || we_2) begin
      q_addr.push_back(9'(waddr));
      q_data.push_back(wdata);
      q_ram.push_back({we_2, we_1});
    end
    if (frame_done) begin
      done_cnt++;
      done_idx = q_addr.size() - 1;
      if (!we_2) done_bad++;
    end
    if (busy) busy_cycles++;
  end

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      #20 sck = 1'b1;
      #20 sck = 1'b0;
    end
  endtask

  task automatic cs_open();
    cs_n = 1'b0;
    #40;
  endtask

  task automatic cs_close();
    #100 cs_n = 1'b1;
    #200;
  endtask

  task automatic test_reset();
    #20;
    n_checks++;
    if ({we_1, we_2, frame_done, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 0000", {we_1, we_2, frame_done, busy});
    end
    n_checks++;
    if (waddr !== '0) begin n_fail++; $display("FAIL reset_waddr: got %0h expected 0", waddr); end
    n_checks++;
    if (wdata !== 16'h0) begin n_fail++; $display("FAIL reset_wdata: got %0h expected 0", wdata); end
`ifdef SPI_FRAME_LOADER_DBUF_EN
    n_checks++;
    if (bank !== 1'b0) begin n_fail++; $display("FAIL reset_bank: got %b expected 0", bank); end
`endif
    #40 i_rst = 1'b0;
    #100;
  endtask

  task automatic test_full_frame();
    int base, d0, db0, bad, first_bad;
    logic [7:0] nb;
    logic hi;
    logic [1:0] er;
    base = q_addr.size(); d0 = done_cnt; db0 = done_bad;
    hi = DBUF & ~exp_bank;
    cs_open();
    spi_byte(8'h01);
    #100;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_on: got %b expected 1", busy); end
    for (int n = 0; n < 512; n++) begin
      nb = 8'(n);
      exp_w[n] = {nb, ~nb};
      spi_byte(nb);
      spi_byte(~nb);
    end
    #200;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_off: got %b expected 0", busy); end
    n_checks++;
    if (q_addr.size() - base !== 512) begin
      n_fail++; $display("FAIL full_count: got %0d expected 512", q_addr.size() - base);
    end else begin
      bad = 0; first_bad = -1;
      for (int n = 0; n < 512; n++) begin
        nb = 8'(n);
        er = (n < 256) ? 2'b01 : 2'b10;
        if (q_ram[base+n] !== er || q_addr[base+n] !== {hi, nb} || q_data[base+n] !== exp_w[n]) begin
          bad++;
          if (first_bad < 0) first_bad = n;
        end
      end
      n_checks++;
      if (bad !== 0) begin
        n_fail++; $display("FAIL full_words: %0d bad words (first %0d: ram %b addr %0h data %0h) expected 0 bad",
                           bad, first_bad, q_ram[base+first_bad], q_addr[base+first_bad], q_data[base+first_bad]);
      end
    end
    n_checks++;
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL full_done_count: got %0d expected 1", done_cnt - d0); end
    n_checks++;
    if (done_idx !== base + 511 || done_bad !== db0) begin
      n_fail++; $display("FAIL full_done_align: got idx %0d bad %0d expected idx %0d bad %0d", done_idx, done_bad, base + 511, db0);
    end
    cs_close();
    if (DBUF) exp_bank = ~exp_bank;
`ifdef SPI_FRAME_LOADER_DBUF_EN
    n_checks++;
    if (bank !== exp_bank) begin n_fail++; $display("FAIL full_bank: got %b expected %b", bank, exp_bank); end
`endif
  endtask

  task automatic test_bad_cmd();
    int base, bc0;
    base = q_addr.size(); bc0 = busy_cycles;
    cs_open();
    spi_byte(8'h55);
    for (int i = 0; i < 20; i++) spi_byte(8'(i * 37 + 1));
    cs_close();
    n_checks++;
    if (q_addr.size() !== base) begin n_fail++; $display("FAIL badcmd_strobes: got %0d expected 0", q_addr.size() - base); end
    n_checks++;
    if (busy_cycles !== bc0) begin n_fail++; $display("FAIL badcmd_busy: got %0d busy cycles expected 0", busy_cycles - bc0); end
  endtask

  task automatic test_abort();
    int base, d0;
    logic hi;
    base = q_addr.size(); d0 = done_cnt;
    hi = DBUF & ~exp_bank;
    cs_open();
    spi_byte(8'h01);
    spi_byte(8'hAB);
    spi_byte(8'hCD);
    spi_byte(8'hEF);
    #200;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_mid: got %b expected 1", busy); end
    cs_close();
    n_checks++;
    if (q_addr.size() - base !== 1) begin
      n_fail++; $display("FAIL abort_count: got %0d expected 1", q_addr.size() - base);
    end else begin
      n_checks++;
      if (q_ram[base] !== 2'b01 || q_addr[base] !== {hi, 8'h00} || q_data[base] !== 16'hABCD) begin
        n_fail++; $display("FAIL abort_word: got ram %b addr %0h data %0h expected ram 01 addr %0h data abcd",
                           q_ram[base], q_addr[base], q_data[base], {hi, 8'h00});
      end
    end
    n_checks++;
    if (done_cnt !== d0) begin n_fail++; $display("FAIL abort_done: got %0d expected 0", done_cnt - d0); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_off: got %b expected 0", busy); end
`ifdef SPI_FRAME_LOADER_DBUF_EN
    n_checks++;
    if (bank !== exp_bank) begin n_fail++; $display("FAIL abort_bank: got %b expected %b", bank, exp_bank); end
`endif
  endtask

  task automatic test_random_frame();
    int base, d0, bad, first_bad;
    logic [7:0] nb;
    logic hi;
    logic [1:0] er;
    base = q_addr.size(); d0 = done_cnt;
    hi = DBUF & ~exp_bank;
    for (int n = 0; n < 512; n++) exp_w[n] = 16'($urandom);
    cs_open();
    spi_byte(8'h01);
    for (int n = 0; n < 512; n++) begin
      spi_byte(exp_w[n][15:8]);
      spi_byte(exp_w[n][7:0]);
    end
    #200;
    n_checks++;
    if (q_addr.size() - base !== 512) begin
      n_fail++; $display("FAIL rand_count: got %0d expected 512", q_addr.size() - base);
    end else begin
      bad = 0; first_bad = -1;
      for (int n = 0; n < 512; n++) begin
        nb = 8'(n);
        er = (n < 256) ? 2'b01 : 2'b10;
        if (q_ram[base+n] !== er || q_addr[base+n] !== {hi, nb} || q_data[base+n] !== exp_w[n]) begin
          bad++;
          if (first_bad < 0) first_bad = n;
        end
      end
      n_checks++;
      if (bad !== 0) begin
        n_fail++; $display("FAIL rand_words: %0d bad words (first %0d: data %0h expected %0h)",
                           bad, first_bad, q_data[base+first_bad], exp_w[first_bad]);
      end
    end
    n_checks++;
    if (done_cnt - d0 !== 1 || done_idx !== base + 511) begin
      n_fail++; $display("FAIL rand_done: got count %0d idx %0d expected 1 idx %0d", done_cnt - d0, done_idx, base + 511);
    end
    cs_close();
    if (DBUF) exp_bank = ~exp_bank;
`ifdef SPI_FRAME_LOADER_DBUF_EN
    n_checks++;
    if (bank !== exp_bank) begin n_fail++; $display("FAIL rand_bank: got %b expected %b", bank, exp_bank); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    int base, bc0;
    logic [7:0] nb;
    logic hi;
    base = q_addr.size();
    cs_open();
    spi_byte(8'h01);
    for (int n = 0; n < 100; n++) begin
      nb = 8'(n);
      spi_byte(nb);
      spi_byte(~nb);
    end
    #100;
    n_checks++;
    if (q_addr.size() - base !== 100) begin n_fail++; $display("FAIL rstmid_pre_count: got %0d expected 100", q_addr.size() - base); end
    i_rst = 1'b1;
    #20;
    n_checks++;
    if ({we_1, we_2, busy} !== 3'b000) begin n_fail++; $display("FAIL rstmid_in_reset: got %b expected 000", {we_1, we_2, busy}); end
    #20 i_rst = 1'b0;
    exp_bank = 1'b0;
    base = q_addr.size(); bc0 = busy_cycles;
    for (int i = 0; i < 12; i++) spi_byte((i % 2 == 0) ? 8'h01 : 8'h5A);
    #200;
    n_checks++;
    if (q_addr.size() !== base) begin n_fail++; $display("FAIL rstmid_no_strobe: got %0d expected 0", q_addr.size() - base); end
    n_checks++;
    if (busy_cycles !== bc0) begin n_fail++; $display("FAIL rstmid_no_busy: got %0d busy cycles expected 0", busy_cycles - bc0); end
    cs_close();
    hi = DBUF & ~exp_bank;
    cs_open();
    spi_byte(8'h01);
    spi_byte(8'h12);
    spi_byte(8'h34);
    #200;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_new_busy: got %b expected 1", busy); end
    n_checks++;
    if (q_addr.size() - base !== 1) begin
      n_fail++; $display("FAIL rstmid_new_count: got %0d expected 1", q_addr.size() - base);
    end else begin
      n_checks++;
      if (q_ram[base] !== 2'b01 || q_addr[base] !== {hi, 8'h00} || q_data[base] !== 16'h1234) begin
        n_fail++; $display("FAIL rstmid_new_word: got ram %b addr %0h data %0h expected ram 01 addr %0h data 1234",
                           q_ram[base], q_addr[base], q_data[base], {hi, 8'h00});
      end
    end
    cs_close();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_off: got %b expected 0", busy); end
`ifdef SPI_FRAME_LOADER_DBUF_EN
    n_checks++;
    if (bank !== 1'b0) begin n_fail++; $display("FAIL rstmid_bank: got %b expected 0", bank); end
`endif
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_bad_cmd();
    test_abort();
    test_random_frame();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_frame_loader.md
Name: spi_frame_loader

Overview:
- Upstream feeder for the matrix driver. Receives LED frames from the ESP32 over a mode-0 SPI slave link.
- Assembles received bytes into 16-bit words. Writes them into the two 256x16 frame RAMs whose read ports the matrix driver scans (RAM 1 = red1 chain, RAM 2 = red2 chain).
- Runs entirely in the LED clock domain. SPI pins are oversampled, never used as a clock.

Parameters:
- CMD_WRITE, 8'h01, command byte that opens a frame write.
- WORDS_PER_RAM, 256, words per RAM; total frame length is 2*WORDS_PER_RAM words.

Ports:
- i_clk  input  1  system clock; must be at least 4x SPI SCK frequency.
- i_rst  input  1  asynchronous, active-high reset.
- i_spi_sck  input  1  SPI clock, asynchronous to i_clk.
- i_spi_cs_n  input  1  SPI chip select, active low.
- i_spi_mosi  input  1  SPI data in, MSB first.
- o_waddr  output  8  RAM write address, shared by both RAMs.
- o_wdata  output  16  RAM write data, as received (high byte first on the wire).
- o_we_1  output  1  single-cycle write strobe for RAM 1.
- o_we_2  output  1  single-cycle write strobe for RAM 2.
- o_frame_done  output  1  one-cycle pulse after the last word of a complete frame is written.
- o_busy  output  1  high from command acceptance until the frame completes or is aborted.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs are 0. State is IDLE. Word counter, shift register and bit counter are cleared.
  - Synchronizers reset to idle values: sck=0, cs_n=1, mosi=0.
- Input conditioning:
  - SCK, CS_N and MOSI each pass through a 2-flop synchronizer. SCK has a third flop for edge detection.
  - A bit is sampled on the detected SCK rising edge while synchronized CS_N=0. The sampled MOSI is the value aligned with that edge.
- Byte assembly:
  - 3-bit counter, 8-bit shift register. A byte is valid in the cycle after its 8th bit.
  - Bit counter clears whenever CS_N is high.
- States:
  - IDLE -> CMD on synchronized CS_N falling edge.
  - CMD:
    - First byte equal to CMD_WRITE -> DATA_HI; o_busy=1; word counter=0.
    - Any other value -> DISCARD.
  - DATA_HI: byte stored as wdata[15:8] -> DATA_LO.
  - DATA_LO: byte stored as wdata[7:0]. In the next cycle:
    - o_wdata holds the full word and o_waddr = word_cnt[7:0].
    - Exactly one of o_we_1 (word_cnt < 256) or o_we_2 (word_cnt >= 256) pulses for one cycle.
    - word_cnt increments. If it was 511: pulse o_frame_done together with the final strobe, clear o_busy, go to DISCARD. Otherwise go to DATA_HI.
  - DISCARD: ignores all bytes. Returns to IDLE on CS_N rising edge.
- Abort:
  - CS_N rising in any state -> IDLE, o_busy=0, no o_frame_done.
  - Words already written stay in RAM. A pending half-word (DATA_LO) is dropped.
- Extra bytes after word 511 within the same CS window are ignored.
- Strobe timing:
  - o_waddr and o_wdata are stable in the cycle o_we_x is high. Outside strobes they hold their last values.
  - Write latency is 1 cycle after the byte completes.
- Counter widths:
  - word_cnt is 9 bits; bit 8 selects the RAM.
  - No wraparound: the frame terminates at 512 words.
- i_rst asserted mid-frame:
  - Immediate return to IDLE.
  - A later CS window without a new CS falling edge is ignored: CMD requires a fresh falling edge.

Optional Feature:
- Macro: SPI_FRAME_LOADER_DBUF_EN.
- When defined:
  - Adds output o_bank (1 bit, reset 0). Writes target the inactive bank, so o_waddr widens to 9 bits: {~o_bank, word_cnt[7:0]}.
  - o_bank toggles in the cycle o_frame_done pulses, so the driver reads bank o_bank tear-free.
  - Aborted frames never toggle o_bank.
- When undefined: single buffer, 8-bit o_waddr, no o_bank port.

Decomposition:
- Shared package (led_pkg):
  - CMD_WRITE value.
  - WORDS_PER_RAM, with RAM address width 8 and data width 16, both shared with the matrix driver.
  - State encoding localparams IDLE/CMD/DATA_HI/DATA_LO/DISCARD.
- One sub-module: spi_byte_rx (synchronizers, edge detect, shift register). It outputs o_byte[7:0], a one-cycle o_byte_valid, and CS fall/rise pulses.

Test Plan:
- Reset, then CS low, send 0x01 then 1024 bytes where word n = {n[7:0], ~n[7:0]}, then CS high.
  - 256 o_we_1 pulses, addr 0..255, data {n,~n}.
  - Then 256 o_we_2 pulses, addr 0..255.
  - Single o_frame_done coincident with the final o_we_2; o_busy low afterwards.
- Command 0x55 followed by 20 bytes -> no write strobes, o_busy stays 0; state returns to IDLE on CS high.
- Send 0x01 and 3 bytes (0xAB, 0xCD, 0xEF), then CS high.
  - One o_we_1 at addr 0 with data 16'hABCD; 0xEF dropped; no o_frame_done.
  - A following full frame writes from addr 0.
- Assert i_rst after 100 words of a frame while SCK keeps toggling with CS low -> no strobes until the next CS falling edge plus 0x01.
- SCK at exactly i_clk/4 with random MOSI -> every received word matches the transmitted word (scoreboard over 512 words).
- With SPI_FRAME_LOADER_DBUF_EN:
  - Two complete frames -> o_bank goes 0->1->0; the first frame writes o_waddr[8]=1, the second o_waddr[8]=0.
  - An aborted third frame leaves o_bank at 0.
